// File: rtl/ring_osc_meter_if.sv
// Bundle between the ring-oscillator meter and its controller: start/tap requests in, enable/status/result out.
interface ring_osc_meter_if #(
    parameter int unsigned COUNT_W = 24
);
    logic               start;
    logic               osc_tap;
    logic               osc_enable;
    logic               busy;
    logic               valid;
    logic [COUNT_W-1:0] count;
    logic               overflow;

    modport master (
        output start,
        output osc_tap,
        input  osc_enable,
        input  busy,
        input  valid,
        input  count,
        input  overflow
    );

    modport slave (
        input  start,
        input  osc_tap,
        output osc_enable,
        output busy,
        output valid,
        output count,
        output overflow
    );
endinterface

// File: rtl/ring_osc_meter.sv
// Ring oscillator frequency meter: enable, settle, count synchronized tap edges over a fixed gate window.
// Define RING_OSC_METER_CONTINUOUS_EN for back-to-back windows after the first start.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | oscillator off, waiting for start
// SETTLE  | oscillator on, timer runs down SETTLE_CYCLES, edges ignored
// MEASURE | oscillator on, edges accumulated for GATE_CYCLES
// DONE    | one cycle: valid pulse, result already latched
module ring_osc_meter #(
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned GATE_CYCLES   = 1048576,
    parameter int unsigned GATE_W        = 21,
    parameter int unsigned COUNT_W       = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    ring_osc_meter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [GATE_W-1:0] SETTLE_LOAD = GATE_W'(SETTLE_CYCLES - 1);
    localparam logic [GATE_W-1:0] GATE_LOAD   = GATE_W'(GATE_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;

    logic               tap_s1;
    logic               tap_s2;
    logic               tap_s3;
    logic               tap_edge;

    logic [GATE_W-1:0]  timer_q;
    logic               timer_zero;

    logic [COUNT_W-1:0] acc_q;
    logic [COUNT_W-1:0] acc_d;
    logic               ovf_q;
    logic               ovf_d;
    logic [COUNT_W-1:0] count_q;
    logic               overflow_q;

    logic               load_settle;
    logic               load_gate;
    logic               acc_clr;
    logic               acc_inc;
    logic               latch_result;
    logic               osc_en_c;
    logic               busy_c;
    logic               valid_c;

    // Two flops resolve metastability on the asynchronous tap; the third gives the previous sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tap_s1 <= 1'b0;
            tap_s2 <= 1'b0;
            tap_s3 <= 1'b0;
        end else begin
            tap_s1 <= bus.osc_tap;
            tap_s2 <= tap_s1;
            tap_s3 <= tap_s2;
        end
    end

    assign tap_edge   = tap_s2 & ~tap_s3;
    assign timer_zero = (timer_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_settle  = 1'b0;
        load_gate    = 1'b0;
        acc_clr      = 1'b0;
        acc_inc      = 1'b0;
        latch_result = 1'b0;
        osc_en_c     = 1'b0;
        busy_c       = 1'b0;
        valid_c      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    load_settle = 1'b1;
                    state_d     = SETTLE;
                end
            end
            SETTLE: begin
                osc_en_c = 1'b1;
                busy_c   = 1'b1;
                if (timer_zero) begin
                    load_gate = 1'b1;
                    acc_clr   = 1'b1;
                    state_d   = MEASURE;
                end
            end
            MEASURE: begin
                osc_en_c = 1'b1;
                busy_c   = 1'b1;
                acc_inc  = tap_edge;
                // Result is captured here, including this cycle's edge, so it is visible alongside valid.
                if (timer_zero) begin
                    latch_result = 1'b1;
                    state_d      = DONE;
                end
            end
            DONE: begin
                busy_c  = 1'b1;
                valid_c = 1'b1;
`ifdef RING_OSC_METER_CONTINUOUS_EN
                osc_en_c  = 1'b1;
                load_gate = 1'b1;
                acc_clr   = 1'b1;
                state_d   = MEASURE;
`else
                state_d   = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
        end else if (load_settle) begin
            timer_q <= SETTLE_LOAD;
        end else if (load_gate) begin
            timer_q <= GATE_LOAD;
        end else if (!timer_zero) begin
            timer_q <= timer_q - GATE_W'(1);
        end
    end

    // Saturating accumulator: once all-ones, further edges only raise the overflow flag.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (acc_inc) begin
            if (&acc_q) begin
                ovf_d = 1'b1;
            end else begin
                acc_d = acc_q + COUNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (acc_clr) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (latch_result) begin
            count_q    <= acc_d;
            overflow_q <= ovf_d;
        end
    end

    assign bus.osc_enable = osc_en_c;
    assign bus.busy       = busy_c;
    assign bus.valid      = valid_c;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
// Directed bench for ring_osc_meter: table of tap periods on two parameterizations plus busy/reset sequences.
`timescale 1ns/1ps
module tb_ring_osc_meter;

    localparam int S_A = 4;
    localparam int S_B = 16;
    localparam int G   = 100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ring_osc_meter_if #(.COUNT_W(8)) ifa ();
    ring_osc_meter_if #(.COUNT_W(3)) ifb ();

    ring_osc_meter #(.SETTLE_CYCLES(S_A), .GATE_CYCLES(G), .GATE_W(8), .COUNT_W(8)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    ring_osc_meter #(.SETTLE_CYCLES(S_B), .GATE_CYCLES(G), .GATE_W(8), .COUNT_W(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic tap = 1'b0;
    int   tap_period = 0;
    int   tap_ph = 0;

    assign ifa.start   = start_a;
    assign ifb.start   = start_b;
    assign ifa.osc_tap = tap;
    assign ifb.osc_tap = tap;

    logic       sel_b = 1'b0;
    logic [7:0] m_count;
    logic       m_valid, m_busy, m_en, m_ovf;
    assign m_count = sel_b ? {5'b0, ifb.count} : ifa.count;
    assign m_valid = sel_b ? ifb.valid : ifa.valid;
    assign m_busy  = sel_b ? ifb.busy : ifa.busy;
    assign m_en    = sel_b ? ifb.osc_enable : ifa.osc_enable;
    assign m_ovf   = sel_b ? ifb.overflow : ifa.overflow;

    // Square-wave tap: high for period/2 clocks, changed on falling clock edges.
    initial begin
        forever begin
            @(negedge clk);
            if (tap_period > 0) begin
                tap = (tap_ph < tap_period / 2);
                tap_ph = (tap_ph + 1) % tap_period;
            end else begin
                tap = 1'b0;
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_tap(input int period);
        tap_period = period;
        tap_ph = 0;
    endtask

    // One measurement; lat counts falling edges after the accepting clock edge (-1 = no valid seen).
    task automatic measure(input bit b, input int stop_at, input int xs1, input int xs2,
                           output int cnt, output bit ovf, output int lat, output int en_lat,
                           output bit done_busy, output bit done_en);
        sel_b = b;
        cnt = -1; ovf = 1'b0; lat = -1; en_lat = -1; done_busy = 1'b0; done_en = 1'b1;
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (stop_at != 0 && i == stop_at) set_tap(0);
            if (i == xs1 || i == xs2) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            if (en_lat < 0 && m_en) en_lat = i;
            if (m_valid) begin
                lat = i;
                cnt = int'(m_count);
                ovf = m_ovf;
                done_busy = m_busy;
                done_en = m_en;
                break;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic check_after(input string tag, input int cnt, input bit ovf);
        @(negedge clk);
        check({tag, " busy_after"}, m_busy, 0);
        check({tag, " en_after"}, m_en, 0);
        check({tag, " valid_after"}, m_valid, 0);
        check({tag, " count_held"}, m_count, cnt);
        check({tag, " ovf_held"}, m_ovf, ovf);
    endtask

    typedef struct {
        bit    b;
        int    period;
        int    lo;
        int    hi;
        bit    ovf;
        string name;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int  cnt, lat, en_lat, exp_lat;
        bit  ovf, dbusy, den;

        vecs[0]  = '{0, 10, 10, 10, 0, "a_p10"};
        vecs[1]  = '{0,  0,  0,  0, 0, "a_static"};
        vecs[2]  = '{0, 20,  5,  5, 0, "a_p20"};
        vecs[3]  = '{0,  7, 14, 15, 0, "a_p7"};
        vecs[4]  = '{0,  4, 25, 25, 0, "a_p4"};
        vecs[5]  = '{0,  3, 33, 34, 0, "a_p3"};
        vecs[6]  = '{1,  4,  7,  7, 1, "b_p4_sat"};
        vecs[7]  = '{1,  0,  0,  0, 0, "b_static"};
        vecs[8]  = '{1, 16,  6,  7, 0, "b_p16"};
        vecs[9]  = '{1, 20,  5,  5, 0, "b_p20"};
        vecs[10] = '{1, 10,  7,  7, 1, "b_p10_sat"};

        repeat (3) @(negedge clk);
        check("reset_en_a", ifa.osc_enable, 0);
        check("reset_busy_a", ifa.busy, 0);
        check("reset_count_a", ifa.count, 0);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef RING_OSC_METER_CONTINUOUS_EN
        begin
            int  last_v, nvalid;
            bit  dropped;
            set_tap(10);
            repeat (6) @(negedge clk);
            sel_b = 1'b0;
            start_a = 1'b1;
            @(posedge clk);
            #1 start_a = 1'b0;
            last_v = 0; nvalid = 0; dropped = 1'b0;
            for (int i = 1; i <= 520 && nvalid < 4; i++) begin
                @(negedge clk);
                if (!ifa.osc_enable || !ifa.busy) dropped = 1'b1;
                if (ifa.valid) begin
                    if (nvalid == 0) check("cont_first_lat", i, 1 + S_A + G);
                    else check("cont_interval", i - last_v, G + 1);
                    check("cont_count", ifa.count, 10);
                    check("cont_ovf", ifa.overflow, 0);
                    last_v = i;
                    nvalid++;
                end
            end
            check("cont_nvalid", nvalid, 4);
            check("cont_en_never_dropped", dropped, 0);
            @(negedge clk);
            #1 rst_n = 1'b0;
            #1;
            check("cont_reset_en", ifa.osc_enable, 0);
            check("cont_reset_count", ifa.count, 0);
            @(negedge clk);
            #1 rst_n = 1'b1;
        end
`else
        for (int v = 0; v < 11; v++) begin
            set_tap(vecs[v].period);
            repeat (6) @(negedge clk);
            measure(vecs[v].b, 0, 0, 0, cnt, ovf, lat, en_lat, dbusy, den);
            exp_lat = 1 + (vecs[v].b ? S_B : S_A) + G;
            check({vecs[v].name, " latency"}, lat, exp_lat);
            check({vecs[v].name, " en_rise"}, en_lat, 1);
            check_range({vecs[v].name, " count"}, cnt, vecs[v].lo, vecs[v].hi);
            check({vecs[v].name, " overflow"}, ovf, vecs[v].ovf);
            check({vecs[v].name, " done_busy"}, dbusy, 1);
            check({vecs[v].name, " done_en"}, den, 0);
            check_after(vecs[v].name, cnt, ovf);
        end

        // Tap active only in the early part of SETTLE; no edge may leak into the window.
        set_tap(4);
        measure(1'b1, 10, 0, 0, cnt, ovf, lat, en_lat, dbusy, den);
        check("settle_only latency", lat, 1 + S_B + G);
        check("settle_only count", cnt, 0);
        check("settle_only overflow", ovf, 0);

        // Extra starts in SETTLE and MEASURE must neither restart nor queue a run.
        set_tap(10);
        repeat (6) @(negedge clk);
        measure(1'b0, 0, 3, 60, cnt, ovf, lat, en_lat, dbusy, den);
        check("busy_start latency", lat, 1 + S_A + G);
        check("busy_start count", cnt, 10);
        check_after("busy_start", 10, 0);
        repeat (5) @(negedge clk);
        check("busy_start not_queued", ifa.busy, 0);

        // Asynchronous reset mid-MEASURE.
        sel_b = 1'b0;
        start_a = 1'b1;
        @(posedge clk);
        #1 start_a = 1'b0;
        repeat (40) @(negedge clk);
        check("pre_reset en", ifa.osc_enable, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset en", ifa.osc_enable, 0);
        check("async_reset busy", ifa.busy, 0);
        check("async_reset count_a", ifa.count, 0);
        check("async_reset count_b", ifb.count, 0);
        check("async_reset ovf_b", ifb.overflow, 0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        begin
            bit seen_valid, seen_en;
            seen_valid = 1'b0; seen_en = 1'b0;
            for (int i = 0; i < 150; i++) begin
                @(negedge clk);
                if (ifa.valid) seen_valid = 1'b1;
                if (ifa.osc_enable) seen_en = 1'b1;
            end
            check("post_reset no_valid", seen_valid, 0);
            check("post_reset no_en", seen_en, 0);
        end
        measure(1'b0, 0, 0, 0, cnt, ovf, lat, en_lat, dbusy, den);
        check("fresh latency", lat, 1 + S_A + G);
        check("fresh count", cnt, 10);
        check("fresh overflow", ovf, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
